// File: rtl/oclib_csr_space_router.sv
// oclib_csr_space_router: routes one CSR requester to one of Spaces targets, with error responses, timeout and a saturating error count
module oclib_csr_space_router #(
  parameter int Spaces = 4,
  parameter int SpaceWidth = 4,
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int TimeoutCycles = 1024,
  parameter logic [DataWidth-1:0] ErrorData = 32'hDEAD_0BAD,
  parameter int ErrorCountWidth = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        inRead,
  input  logic                        inWrite,
  input  logic [SpaceWidth-1:0]       inSpace,
  input  logic [AddressWidth-1:0]     inAddress,
  input  logic [DataWidth-1:0]        inWdata,
  output logic                        inReady,
  output logic [DataWidth-1:0]        inRdata,
  output logic                        inError,
  output logic [Spaces-1:0]           outRead,
  output logic [Spaces-1:0]           outWrite,
  output logic [AddressWidth-1:0]     outAddress,
  output logic [DataWidth-1:0]        outWdata,
  input  logic [Spaces-1:0]           outReady,
  input  logic [Spaces*DataWidth-1:0] outRdata,
  input  logic [Spaces-1:0]           outError,
  output logic                        busy,
  output logic [ErrorCountWidth-1:0]  errorCount
);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND, GAP} state_t;
  state_t state, state_n;
  logic [SpaceWidth-1:0] sel;
  logic is_write, err, req, bad, hit, tmo, hit_err;
  logic [31:0] tcnt;
  logic [Spaces-1:0] sel_oh;
  logic [DataWidth-1:0] sel_data;
  assign req = inRead | inWrite;
  assign bad = (inRead & inWrite) | (32'(inSpace) >= Spaces);
  assign sel_oh = Spaces'(1) << sel;
  assign hit = |(outReady & sel_oh);
  assign hit_err = |(outError & sel_oh);
  assign tmo = (TimeoutCycles != 0) && (tcnt == 32'(TimeoutCycles - 1));
  assign outRead = (state == WAIT && !is_write) ? sel_oh : '0;
  assign outWrite = (state == WAIT && is_write) ? sel_oh : '0;
  assign inReady = state == RESPOND;
  assign inError = inReady & err;
  assign busy = state != IDLE;
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < Spaces; i++)
      if (sel_oh[i]) sel_data = outRdata[i*DataWidth +: DataWidth];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req ? (bad ? RESPOND : WAIT) : IDLE;
      WAIT:    state_n = (hit | tmo) ? RESPOND : WAIT;
      RESPOND: state_n = GAP;
      default: state_n = req ? GAP : IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      sel <= '0;
      is_write <= 1'b0;
      err <= 1'b0;
      tcnt <= '0;
      inRdata <= '0;
      outAddress <= '0;
      outWdata <= '0;
      errorCount <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        sel <= inSpace;
        is_write <= inWrite;
        outAddress <= inAddress;
        outWdata <= inWdata;
        err <= bad;
        tcnt <= '0;
        inRdata <= bad ? ErrorData : '0;
      end
      if (state == WAIT) begin
        tcnt <= tcnt + 32'd1;
        if (hit) begin
          err <= hit_err;
          inRdata <= hit_err ? ErrorData : is_write ? '0 : sel_data;
        end else if (tmo) begin
          err <= 1'b1;
          inRdata <= ErrorData;
        end
      end
      if (state == RESPOND && err && !(&errorCount)) errorCount <= errorCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_oclib_csr_space_router.sv
// tb_oclib_csr_space_router: table-driven scoreboard bench for oclib_csr_space_router
module tb_oclib_csr_space_router;
  localparam int S = 4;
  localparam int DW = 32;
  localparam int CW = 8;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic in_read = 1'b0, in_write = 1'b0;
  logic [3:0] in_space = '0;
  logic [31:0] in_address = '0, in_wdata = '0;
  logic in_ready, in_error, busy;
  logic [DW-1:0] in_rdata;
  logic [S-1:0] out_read, out_write;
  logic [31:0] out_address, out_wdata;
  logic [S-1:0] out_ready = '0, out_error = '0;
  logic [S*DW-1:0] out_rdata = '0;
  logic [CW-1:0] error_count;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    bit rd; bit wr; logic [3:0] space; logic [31:0] addr; logic [31:0] wdata;
    int dly; logic [31:0] rdata; bit rerr; int hold; int stray;
    int lat; bit err; logic [31:0] data; int strobes; int cnt;
  } vec_t;
  typedef struct { int lat; bit err; logic [31:0] data; } exp_t;
  exp_t sb[$];
  vec_t vecs[8];
  oclib_csr_space_router #(.TimeoutCycles(8), .ErrorCountWidth(CW)) dut (
    .clock(clock), .reset(reset),
    .inRead(in_read), .inWrite(in_write), .inSpace(in_space), .inAddress(in_address), .inWdata(in_wdata),
    .inReady(in_ready), .inRdata(in_rdata), .inError(in_error),
    .outRead(out_read), .outWrite(out_write), .outAddress(out_address), .outWdata(out_wdata),
    .outReady(out_ready), .outRdata(out_rdata), .outError(out_error),
    .busy(busy), .errorCount(error_count)
  );
  always #5 clock = ~clock;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int scnt, rcyc;
    bit sok;
    exp_t e;
    logic [S-1:0] oh;
    scnt = 0;
    rcyc = -1;
    sok = 1'b1;
    oh = S'(1) << v.space[1:0];
    for (int i = 0; i < S; i++) out_rdata[i*DW +: DW] = 32'hF0F0_0000 | i;
    @(posedge clock); #1;
    in_read = v.rd; in_write = v.wr; in_space = v.space; in_address = v.addr; in_wdata = v.wdata;
    sb.push_back('{v.lat, v.err, v.data});
    for (int c = 1; c <= 26; c++) begin
      @(posedge clock); #1;
      out_ready = '0;
      out_error = '0;
      if (|out_read || |out_write) begin
        scnt++;
        if (scnt == 1) begin
          chk("out_address", out_address, v.addr);
          if (v.wr) chk("out_wdata", out_wdata, v.wdata);
        end
        if (out_read !== (v.rd ? oh : '0) || out_write !== (v.wr ? oh : '0) || in_ready) sok = 1'b0;
        if (scnt == 1 && (v.dly < 0 || v.dly >= 2)) out_ready[(v.space + 1) % S] = 1'b1;
        if (scnt == v.dly + 1) begin
          out_ready[v.space[1:0]] = 1'b1;
          out_error[v.space[1:0]] = v.rerr;
          out_rdata[v.space[1:0]*DW +: DW] = v.rdata;
        end
      end
      if (in_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_response: cycle %0d, none expected", c);
        end else begin
          e = sb.pop_front();
          chk("latency", c, e.lat);
          chk("in_error", in_error, e.err);
          chk("in_rdata", in_rdata, e.data);
        end
        rcyc = c;
      end
      if (rcyc >= 0 && c == rcyc + v.hold) begin
        in_read = 1'b0;
        in_write = 1'b0;
      end
      if (rcyc >= 0 && v.stray > 0 && c == rcyc + v.stray) out_ready[v.space[1:0]] = 1'b1;
    end
    if (sb.size() != 0) begin
      void'(sb.pop_front());
      n_cmp++;
      n_bad++;
      $display("FAIL response_timeout: no inReady within 26 cycles, expected 1");
    end
    in_read = 1'b0;
    in_write = 1'b0;
    out_ready = '0;
    @(posedge clock); #1;
    chk("strobe_cycles", scnt, v.strobes);
    chk("strobe_value", sok, 1'b1);
    chk("error_count", error_count, v.cnt);
    chk("busy_end", busy, 1'b0);
  endtask
  initial begin
    //         rd wr sp  addr          wdata         dly rdata         re hold stray lat err data           strb cnt
    vecs[0] = '{1, 0, 2, 32'h0000_0100, 32'h0,        3,  32'h1234_5678, 0, 0, 0, 5, 0, 32'h1234_5678, 4, 0};
    vecs[1] = '{0, 1, 0, 32'h0000_0204, 32'hA5A5_A5A5, 0, 32'h1111_1111, 1, 0, 0, 2, 1, 32'hDEAD_0BAD, 1, 1};
    vecs[2] = '{1, 0, 7, 32'h0000_0308, 32'h0,        0,  32'h0,         0, 3, 0, 1, 1, 32'hDEAD_0BAD, 0, 2};
    vecs[3] = '{1, 0, 1, 32'h0000_040C, 32'h0,        -1, 32'h0,         0, 0, 5, 9, 1, 32'hDEAD_0BAD, 8, 3};
    vecs[4] = '{1, 1, 3, 32'h0000_0510, 32'h5,        0,  32'h0,         0, 0, 0, 1, 1, 32'hDEAD_0BAD, 0, 4};
    vecs[5] = '{0, 1, 3, 32'h0000_0614, 32'hCAFE_F00D, 1, 32'h9999_9999, 0, 0, 0, 3, 0, 32'h0,         2, 4};
    vecs[6] = '{1, 0, 3, 32'h0000_0718, 32'h0,        7,  32'h7766_5544, 0, 0, 0, 9, 0, 32'h7766_5544, 8, 4};
    vecs[7] = '{1, 0, 0, 32'h0000_081C, 32'h0,        2,  32'h4242_4242, 1, 0, 0, 4, 1, 32'hDEAD_0BAD, 3, 5};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_in_error", in_error, 1'b0);
    chk("rst_out_read", out_read, '0);
    chk("rst_out_write", out_write, '0);
    chk("rst_error_count", error_count, '0);
    chk("rst_in_rdata", in_rdata, '0);
    chk("rst_out_address", out_address, '0);
    chk("rst_out_wdata", out_wdata, '0);
    reset = 1'b1;
    foreach (vecs[i]) run(vecs[i]);
    @(posedge clock); #1;
    in_read = 1'b1; in_space = 4'd1; in_address = 32'h0000_0900;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_strobe", out_read, 4'b0010);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_out_read", out_read, '0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b0);
    chk("rst_mid_error_count", error_count, '0);
    reset = 1'b1;
    in_read = 1'b0;
    run('{1, 0, 1, 32'h0000_0A00, 32'h0, 1, 32'h0BAD_CAFE, 0, 0, 0, 3, 0, 32'h0BAD_CAFE, 2, 0});
    for (int i = 0; i < 300; i++) begin
      @(posedge clock); #1;
      in_read = 1'b1; in_write = 1'b1; in_space = 4'd0;
      @(posedge clock); #1;
      if (i == 0) chk("collision_error", in_error, 1'b1);
      if (i == 0) chk("collision_no_strobe", out_read | out_write, '0);
      in_read = 1'b0; in_write = 1'b0;
      @(posedge clock); #1;
      if (i == 253) chk("count_254", error_count, 8'd254);
      if (i == 299) chk("count_saturated", error_count, 8'hFF);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
